// File: rtl/gridworld_episode.sv
// Gridworld episode engine: one 8-way move per accepted action, terminal on trap/goal/horizon.
// Latency 1 cycle per accepted action; act_ready is state-decoded (high only in RUN), never from act_valid.
module gridworld_episode #(
  parameter int COORD_W      = 3,
  parameter int HORIZON      = 16,
  parameter int WRAP         = 1,
  parameter int X0           = 2,
  parameter int Y0           = 3,
  parameter int GOAL_XLO     = 3,
  parameter int GOAL_XHI     = 4,
  parameter int GOAL_YLO     = 2,
  parameter int GOAL_YHI     = 5,
  parameter int STOP_ON_GOAL = 1,
  parameter int CNT_W        = $clog2(HORIZON + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               act_valid,
  output logic               act_ready,
  input  logic [2:0]         act,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic [CNT_W-1:0]   step_cnt,
  output logic               lbl_goal,
  output logic               lbl_trap,
  output logic               lbl_edge,
  output logic               done,
  output logic [1:0]         outcome
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [COORD_W-1:0] MAXC  = '1;
  localparam logic [COORD_W-1:0] ONE   = COORD_W'(1);
  localparam logic [COORD_W-1:0] X0C   = COORD_W'(X0);
  localparam logic [COORD_W-1:0] Y0C   = COORD_W'(Y0);
  localparam logic [COORD_W-1:0] GXLO  = COORD_W'(GOAL_XLO);
  localparam logic [COORD_W-1:0] GXHI  = COORD_W'(GOAL_XHI);
  localparam logic [COORD_W-1:0] GYLO  = COORD_W'(GOAL_YLO);
  localparam logic [COORD_W-1:0] GYHI  = COORD_W'(GOAL_YHI);
  localparam logic [CNT_W-1:0]   HOR_C = CNT_W'(HORIZON);

  localparam logic [1:0] D_Z = 2'd0;
  localparam logic [1:0] D_P = 2'd1;
  localparam logic [1:0] D_M = 2'd2;

  state_t               state_q;
  logic [COORD_W-1:0]   pos_x_q, pos_y_q;
  logic [CNT_W-1:0]     cnt_q;
  logic [1:0]           outcome_q;
  logic                 ready_q, done_q;

  logic [1:0]           dx, dy;
  logic [COORD_W-1:0]   pos_x_d, pos_y_d;
  logic [CNT_W-1:0]     cnt_d;
  logic                 trap_d, goal_d;

  // Per-axis move: wrap modulo 2^COORD_W, or clamp at 0/MAX when WRAP=0.
  function automatic logic [COORD_W-1:0] step_axis(input logic [COORD_W-1:0] v,
                                                   input logic [1:0] d);
    step_axis = v;
    if (d == D_P) begin
      if (WRAP != 0 || v != MAXC) step_axis = v + ONE;
    end else if (d == D_M) begin
      if (WRAP != 0 || v != '0) step_axis = v - ONE;
    end
  endfunction

  function automatic logic is_trap(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    is_trap = (x == '0 || x == MAXC) && (y == '0 || y == MAXC);
  endfunction

  function automatic logic in_goal(input logic [COORD_W-1:0] x, input logic [COORD_W-1:0] y);
    in_goal = (x >= GXLO) && (x <= GXHI) && (y >= GYLO) && (y <= GYHI);
  endfunction

  always_comb begin
    dx = D_Z;
    dy = D_Z;
    case (act)
      3'd0: begin dx = D_Z; dy = D_P; end
      3'd1: begin dx = D_P; dy = D_P; end
      3'd2: begin dx = D_P; dy = D_Z; end
      3'd3: begin dx = D_P; dy = D_M; end
      3'd4: begin dx = D_Z; dy = D_M; end
      3'd5: begin dx = D_M; dy = D_M; end
      3'd6: begin dx = D_M; dy = D_Z; end
      default: begin dx = D_M; dy = D_P; end
    endcase
  end

  always_comb begin
    pos_x_d = step_axis(pos_x_q, dx);
    pos_y_d = step_axis(pos_y_q, dy);
    cnt_d   = cnt_q + CNT_W'(1);
    trap_d  = is_trap(pos_x_d, pos_y_d);
    goal_d  = in_goal(pos_x_d, pos_y_d);
  end

  // start outranks any same-cycle action in every state; the start cell is never terminal-checked.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pos_x_q   <= X0C;
      pos_y_q   <= Y0C;
      cnt_q     <= '0;
      outcome_q <= 2'd0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
    end else if (start) begin
      state_q   <= RUN;
      pos_x_q   <= X0C;
      pos_y_q   <= Y0C;
      cnt_q     <= '0;
      outcome_q <= 2'd0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
    end else if (state_q == RUN && act_valid && ready_q) begin
      pos_x_q <= pos_x_d;
      pos_y_q <= pos_y_d;
      cnt_q   <= cnt_d;
      if (trap_d) begin
        state_q   <= DONE;
        outcome_q <= 2'd2;
        ready_q   <= 1'b0;
        done_q    <= 1'b1;
      end else if (goal_d && STOP_ON_GOAL != 0) begin
        state_q   <= DONE;
        outcome_q <= 2'd1;
        ready_q   <= 1'b0;
        done_q    <= 1'b1;
      end else if (cnt_d == HOR_C) begin
        state_q   <= DONE;
        outcome_q <= 2'd3;
        ready_q   <= 1'b0;
        done_q    <= 1'b1;
      end
    end
  end

  assign act_ready = ready_q;
  assign done      = done_q;
  assign outcome   = outcome_q;
  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign step_cnt  = cnt_q;
  assign lbl_goal  = in_goal(pos_x_q, pos_y_q);
  assign lbl_trap  = is_trap(pos_x_q, pos_y_q);
  assign lbl_edge  = (pos_y_q == '0) || (pos_y_q == MAXC);

endmodule

// File: tb/tb_gridworld_episode.sv
// Directed bench: four engine variants (default, WRAP=0, HORIZON=4, STOP_ON_GOAL=0) share one stimulus.
module tb_gridworld_episode;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic act_valid = 1'b0;
  logic [2:0] act = 3'd0;

  logic       rdy [4];
  logic [2:0] px  [4];
  logic [2:0] py  [4];
  logic [4:0] sc0, sc1, sc3;
  logic [2:0] sc2;
  logic       lg  [4];
  logic       lt  [4];
  logic       le  [4];
  logic       dn  [4];
  logic [1:0] oc  [4];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  gridworld_episode u_def (
    .clk(clk), .rst_n(rst_n), .start(start), .act_valid(act_valid), .act_ready(rdy[0]), .act(act),
    .pos_x(px[0]), .pos_y(py[0]), .step_cnt(sc0), .lbl_goal(lg[0]), .lbl_trap(lt[0]),
    .lbl_edge(le[0]), .done(dn[0]), .outcome(oc[0]));

  gridworld_episode #(.WRAP(0)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .act_valid(act_valid), .act_ready(rdy[1]), .act(act),
    .pos_x(px[1]), .pos_y(py[1]), .step_cnt(sc1), .lbl_goal(lg[1]), .lbl_trap(lt[1]),
    .lbl_edge(le[1]), .done(dn[1]), .outcome(oc[1]));

  gridworld_episode #(.HORIZON(4)) u_h4 (
    .clk(clk), .rst_n(rst_n), .start(start), .act_valid(act_valid), .act_ready(rdy[2]), .act(act),
    .pos_x(px[2]), .pos_y(py[2]), .step_cnt(sc2), .lbl_goal(lg[2]), .lbl_trap(lt[2]),
    .lbl_edge(le[2]), .done(dn[2]), .outcome(oc[2]));

  gridworld_episode #(.STOP_ON_GOAL(0)) u_ng (
    .clk(clk), .rst_n(rst_n), .start(start), .act_valid(act_valid), .act_ready(rdy[3]), .act(act),
    .pos_x(px[3]), .pos_y(py[3]), .step_cnt(sc3), .lbl_goal(lg[3]), .lbl_trap(lt[3]),
    .lbl_edge(le[3]), .done(dn[3]), .outcome(oc[3]));

  task automatic apply_reset();
    rst_n = 1'b0; start = 1'b0; act_valid = 1'b0; act = 3'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_act(input logic [2:0] a);
    @(negedge clk);
    act_valid = 1'b1;
    act = a;
    @(posedge clk);
    #1 act_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; act_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if ({px[0], py[0]} !== {3'd2, 3'd3}) begin failures++; $display("FAIL reset_pos got=(%0d,%0d) exp=(2,3)", px[0], py[0]); end
    checks++; if ({sc0, oc[0], dn[0], rdy[0]} !== {5'd0, 2'd0, 1'b0, 1'b0}) begin failures++; $display("FAIL reset_ctrl got cnt=%0d oc=%0d done=%0b rdy=%0b exp 0,0,0,0", sc0, oc[0], dn[0], rdy[0]); end
    checks++; if ({lg[0], lt[0], le[0]} !== 3'b000) begin failures++; $display("FAIL reset_labels got=%b exp=000", {lg[0], lt[0], le[0]}); end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    checks++; if (rdy[0] !== 1'b0) begin failures++; $display("FAIL idle_ready got=%0b exp=0", rdy[0]); end
    pulse_start();
    checks++; if (rdy[0] !== 1'b1) begin failures++; $display("FAIL run_ready got=%0b exp=1", rdy[0]); end
  endtask

  task automatic test_goal();
    apply_reset(); pulse_start();
    do_act(3'd2);
    checks++; if ({px[0], py[0]} !== {3'd3, 3'd3}) begin failures++; $display("FAIL goal_pos got=(%0d,%0d) exp=(3,3)", px[0], py[0]); end
    checks++; if ({lg[0], dn[0], oc[0], sc0, rdy[0]} !== {1'b1, 1'b1, 2'd1, 5'd1, 1'b0}) begin failures++; $display("FAIL goal_state got lg=%0b done=%0b oc=%0d cnt=%0d rdy=%0b exp 1,1,1,1,0", lg[0], dn[0], oc[0], sc0, rdy[0]); end
    checks++; if ({lg[3], dn[3], oc[3], rdy[3]} !== {1'b1, 1'b0, 2'd0, 1'b1}) begin failures++; $display("FAIL nogoal_state got lg=%0b done=%0b oc=%0d rdy=%0b exp 1,0,0,1", lg[3], dn[3], oc[3], rdy[3]); end
    do_act(3'd2);
    checks++; if ({px[0], py[0], sc0} !== {3'd3, 3'd3, 5'd1}) begin failures++; $display("FAIL goal_hold got=(%0d,%0d) cnt=%0d exp=(3,3) cnt=1", px[0], py[0], sc0); end
    pulse_start();
    checks++; if ({px[0], py[0], sc0, oc[0], dn[0], rdy[0]} !== {3'd2, 3'd3, 5'd0, 2'd0, 1'b0, 1'b1}) begin failures++; $display("FAIL done_restart got=(%0d,%0d) cnt=%0d oc=%0d done=%0b rdy=%0b exp=(2,3),0,0,0,1", px[0], py[0], sc0, oc[0], dn[0], rdy[0]); end
  endtask

  task automatic test_wrap();
    logic [2:0] exp_w [3];
    logic [2:0] exp_s [3];
    exp_w[0] = 3'd1; exp_w[1] = 3'd0; exp_w[2] = 3'd7;
    exp_s[0] = 3'd1; exp_s[1] = 3'd0; exp_s[2] = 3'd0;
    apply_reset(); pulse_start();
    for (int i = 0; i < 3; i++) begin
      do_act(3'd6);
      checks++; if ({px[0], py[0]} !== {exp_w[i], 3'd3}) begin failures++; $display("FAIL wrap_pos%0d got=(%0d,%0d) exp=(%0d,3)", i, px[0], py[0], exp_w[i]); end
      checks++; if ({px[1], py[1]} !== {exp_s[i], 3'd3}) begin failures++; $display("FAIL sat_pos%0d got=(%0d,%0d) exp=(%0d,3)", i, px[1], py[1], exp_s[i]); end
    end
    checks++; if ({dn[0], sc0} !== {1'b0, 5'd3}) begin failures++; $display("FAIL wrap_end got done=%0b cnt=%0d exp 0,3", dn[0], sc0); end
    checks++; if ({dn[1], sc1} !== {1'b0, 5'd3}) begin failures++; $display("FAIL sat_cnt got done=%0b cnt=%0d exp 0,3", dn[1], sc1); end
  endtask

  task automatic test_trap();
    logic [2:0] acts [3];
    logic [5:0] exp_p [3];
    acts[0] = 3'd5; acts[1] = 3'd5; acts[2] = 3'd4;
    exp_p[0] = {3'd1, 3'd2}; exp_p[1] = {3'd0, 3'd1}; exp_p[2] = {3'd0, 3'd0};
    apply_reset(); pulse_start();
    for (int i = 0; i < 3; i++) begin
      do_act(acts[i]);
      checks++; if ({px[0], py[0]} !== exp_p[i]) begin failures++; $display("FAIL trap_pos%0d got=(%0d,%0d) exp=(%0d,%0d)", i, px[0], py[0], exp_p[i][5:3], exp_p[i][2:0]); end
    end
    checks++; if ({lt[0], le[0], oc[0], dn[0], rdy[0]} !== {1'b1, 1'b1, 2'd2, 1'b1, 1'b0}) begin failures++; $display("FAIL trap_state got trap=%0b edge=%0b oc=%0d done=%0b rdy=%0b exp 1,1,2,1,0", lt[0], le[0], oc[0], dn[0], rdy[0]); end
  endtask

  task automatic test_timeout();
    apply_reset(); pulse_start();
    for (int i = 0; i < 4; i++) begin
      do_act(3'd0);
      checks++; if ({px[2], py[2]} !== {3'd2, 3'(4 + i)}) begin failures++; $display("FAIL tmo_pos%0d got=(%0d,%0d) exp=(2,%0d)", i, px[2], py[2], 4 + i); end
      if (i == 2) begin
        checks++; if (dn[2] !== 1'b0) begin failures++; $display("FAIL tmo_early got done=%0b exp=0", dn[2]); end
      end
    end
    checks++; if ({le[2], oc[2], sc2, dn[2]} !== {1'b1, 2'd3, 3'd4, 1'b1}) begin failures++; $display("FAIL tmo_state got edge=%0b oc=%0d cnt=%0d done=%0b exp 1,3,4,1", le[2], oc[2], sc2, dn[2]); end
    checks++; if ({dn[0], sc0, py[0]} !== {1'b0, 5'd4, 3'd7}) begin failures++; $display("FAIL tmo_h16 got done=%0b cnt=%0d y=%0d exp 0,4,7", dn[0], sc0, py[0]); end
    do_act(3'd0);
    checks++; if ({sc2, py[2]} !== {3'd4, 3'd7}) begin failures++; $display("FAIL tmo_cap got cnt=%0d y=%0d exp 4,7", sc2, py[2]); end
  endtask

  task automatic test_handshake();
    apply_reset(); pulse_start();
    do_act(3'd6);
    @(posedge clk); #1;
    checks++; if ({px[0], py[0], sc0} !== {3'd1, 3'd3, 5'd1}) begin failures++; $display("FAIL hs_gap got=(%0d,%0d) cnt=%0d exp=(1,3) cnt=1", px[0], py[0], sc0); end
    do_act(3'd0);
    checks++; if ({px[0], py[0], sc0} !== {3'd1, 3'd4, 5'd2}) begin failures++; $display("FAIL hs_move got=(%0d,%0d) cnt=%0d exp=(1,4) cnt=2", px[0], py[0], sc0); end
    @(negedge clk);
    act_valid = 1'b1; act = 3'd0; start = 1'b1;
    @(posedge clk); #1;
    act_valid = 1'b0; start = 1'b0;
    checks++; if ({px[0], py[0], sc0, rdy[0]} !== {3'd2, 3'd3, 5'd0, 1'b1}) begin failures++; $display("FAIL hs_start_wins got=(%0d,%0d) cnt=%0d rdy=%0b exp=(2,3) cnt=0 rdy=1", px[0], py[0], sc0, rdy[0]); end
  endtask

  task automatic test_back_to_back();
    apply_reset(); pulse_start();
    @(negedge clk);
    act_valid = 1'b1; act = 3'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checks++; if ({px[0], py[0], sc0} !== {3'd2, 3'(4 + i), 5'(i + 1)}) begin failures++; $display("FAIL b2b_%0d got=(%0d,%0d) cnt=%0d exp=(2,%0d) cnt=%0d", i, px[0], py[0], sc0, 4 + i, i + 1); end
    end
    act_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    apply_reset(); pulse_start();
    do_act(3'd6);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({px[0], py[0], sc0, rdy[0], dn[0], oc[0]} !== {3'd2, 3'd3, 5'd0, 1'b0, 1'b0, 2'd0}) begin failures++; $display("FAIL async_rst got=(%0d,%0d) cnt=%0d rdy=%0b done=%0b oc=%0d exp=(2,3),0,0,0,0", px[0], py[0], sc0, rdy[0], dn[0], oc[0]); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_goal();
    test_wrap();
    test_trap();
    test_timeout();
    test_handshake();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
